// File: rtl/tl_pkg.sv
// TileLink-UL channel types shared between the core request side and the data-memory slave.
// Holds the opcode enums, the captured A request and the slave FSM state.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } tl_d_op_e;

  localparam int TL_AW = 12;
  localparam int TL_DW = 32;
  localparam int TL_MW = TL_DW / 8;

  // Opcode is kept as raw bits so that illegal encodings can be captured and answered.
  typedef struct packed {
    logic [2:0]       opcode;
    logic [TL_AW-1:0] address;
    logic [TL_MW-1:0] mask;
    logic [TL_DW-1:0] data;
  } tl_a_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  function automatic logic is_legal_a_op(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port word RAM with per-byte write enables: synchronous write, combinational read.
// Contents are undefined at power-up.
module sp_ram_be #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/tl_ul_dmem_slave.sv
// TileLink-UL data-memory slave: one outstanding request, region decode on address[11:10],
// RAM access after a fixed latency and a D response held until the master takes it.
module tl_ul_dmem_slave
  import tl_pkg::*;
#(
  parameter int         DEPTH     = 1024,
  parameter logic [1:0] REGION    = 2'b01,
  parameter int         LATENCY   = 1,
  parameter string      INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [2:0]  a_opcode_i,
  input  logic [11:0] a_address_i,
  input  logic [3:0]  a_mask_i,
  input  logic [31:0] a_data_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [2:0]  d_opcode_o,
  output logic [31:0] d_data_o,
  output logic        d_error_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 3;

  dmem_state_e      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;
  logic             do_op;
  tl_a_req_t        req_q;

  logic             hit;
  logic             legal;
  logic [3:0]       ram_be;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;
  logic [2:0]       resp_op;
  logic [31:0]      resp_data;
  logic             resp_err;

  assign a_ready_o = (state == IDLE) && !reset;
  assign accept    = a_valid_i && a_ready_o;
  assign d_valid_o = (state == RESP);

  // Control: state register and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    do_op   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          do_op   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (d_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture: only on an accepted beat, so idle-bus garbage never reaches state
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.opcode  <= a_opcode_i;
      req_q.address <= a_address_i;
      req_q.mask    <= a_mask_i;
      req_q.data    <= a_data_i;
    end
  end

  // Decode and response formation from the captured request
  always_comb begin
    hit       = (req_q.address[11:10] == REGION);
    legal     = is_legal_a_op(req_q.opcode);
    ram_be    = (req_q.opcode == PUT_FULL) ? 4'hF : req_q.mask;
    resp_op   = ACK;
    resp_data = '0;
    resp_err  = 1'b0;
    if (!hit || !legal) begin
      resp_err = 1'b1;
      if (req_q.opcode == GET) resp_op = ACK_DATA;
    end else if (req_q.opcode == GET) begin
      resp_op   = ACK_DATA;
      resp_data = ram_rdata;
    end
  end

  // A reset arriving in the exit cycle suppresses the write so nothing half-done is committed
  assign ram_we = (do_op && !reset && hit && legal && (req_q.opcode != GET)) ? ram_be : 4'h0;

  sp_ram_be #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (req_q.address[AW-1:0]),
    .wdata(req_q.data),
    .rdata(ram_rdata)
  );

  // D channel registers: loaded once per transaction, stable through the RESP stall
  always_ff @(posedge clk) begin
    if (reset) begin
      d_opcode_o <= '0;
      d_data_o   <= '0;
      d_error_o  <= 1'b0;
    end else if (do_op) begin
      d_opcode_o <= resp_op;
      d_data_o   <= resp_data;
      d_error_o  <= resp_err;
    end
  end

endmodule
